rd_reorder_requester: RTL and testbench

In-order read requester for the user-side read path into `server_io`. It accepts 32-bit cache-line read addresses from a client and allocates a tag for each one. It issues the reads on the `rq_tx_rd_*` port and takes the out-of-order responses from the `io_rx_rd_*` port into a tag-indexed reorder buffer. Data lines are returned to the client strictly in request order over a valid/ready port.

---
 rtl/rd_reorder_requester.sv | 148 ++++++++++++++
 tb/tb_rd_reorder_requester.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rd_reorder_requester.sv
// In-order read requester: allocates tags, issues reads to server_io, captures
// out-of-order responses into a tag-indexed buffer and retires them in order
// through a 2-entry registered output FIFO.
module rd_reorder_requester #(
  parameter int TAG_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                usr_rd_valid,
  output logic                usr_rd_ready,
  input  logic [31:0]         usr_rd_addr,
  output logic                rq_tx_rd_valid,
  input  logic                rq_tx_rd_ready,
  output logic [44:0]         rq_tx_rd_hdr,
  input  logic                io_rx_rd_valid,
  input  logic [12:0]         io_rx_rd_tag,
  input  logic [511:0]        io_rx_data,
  output logic                usr_rx_valid,
  input  logic                usr_rx_ready,
  output logic [511:0]        usr_rx_data,
  output logic [TAG_BITS:0]   outstanding,
  output logic                err_stray
);
  localparam int DEPTH = 1 << TAG_BITS;

  logic [TAG_BITS-1:0]  tail_q, tail_d, head_q, head_d;
  logic [TAG_BITS:0]    outstanding_q, outstanding_d;
  logic [DEPTH-1:0]     alloc_q, alloc_d, vld_q, vld_d;
  logic                 err_q, err_d;
  logic                 rd_pend_q, rd_pend_d;
  logic [511:0]         ram_rdata_q, ram_rdata_d;
  logic [1:0][511:0]    fifo_q, fifo_d;
  logic                 fifo_rptr_q, fifo_rptr_d, fifo_wptr_q, fifo_wptr_d;
  logic [1:0]           fifo_cnt_q, fifo_cnt_d;
  logic [511:0]         mem [DEPTH];

  logic                 issue, capture, stray, pop, deq, space;
  logic [TAG_BITS-1:0]  tag_idx;
  logic [1:0]           occ_after;

  // Issue handshake is purely combinational: server_io writes on valid alone,
  // so valid is only ever raised when ready is already high.
  always_comb begin
    usr_rd_ready   = rq_tx_rd_ready & ~outstanding_q[TAG_BITS];
    issue          = usr_rd_valid & usr_rd_ready;
    rq_tx_rd_valid = issue;
    rq_tx_rd_hdr   = {usr_rd_addr, {(13-TAG_BITS){1'b0}}, tail_q};
  end

  // Response legality, output-space check and retire decision.
  always_comb begin
    tag_idx   = io_rx_rd_tag[TAG_BITS-1:0];
    capture   = io_rx_rd_valid & ((io_rx_rd_tag >> TAG_BITS) == 13'd0)
                & alloc_q[tag_idx] & ~vld_q[tag_idx];
    stray     = io_rx_rd_valid & ~capture;
    deq       = usr_rx_valid & usr_rx_ready;
    // Count the in-flight RAM read as occupied so the FIFO never overflows.
    occ_after = fifo_cnt_q + {1'b0, rd_pend_q} - {1'b0, deq};
    space     = ~occ_after[1];
    pop       = vld_q[head_q] & space;
  end

  // Next-state for pointers, slot bits, counters and the output FIFO.
  always_comb begin
    tail_d        = tail_q;
    head_d        = head_q;
    alloc_d       = alloc_q;
    vld_d         = vld_q;
    outstanding_d = outstanding_q;
    err_d         = err_q | stray;
    rd_pend_d     = pop;
    ram_rdata_d   = ram_rdata_q;
    fifo_d        = fifo_q;
    fifo_rptr_d   = fifo_rptr_q;
    fifo_wptr_d   = fifo_wptr_q;
    fifo_cnt_d    = fifo_cnt_q;

    // A pop slot always has vld set, a capture slot never does, so these
    // bit updates cannot collide.
    if (pop) begin
      alloc_d[head_q] = 1'b0;
      vld_d[head_q]   = 1'b0;
      head_d          = head_q + TAG_BITS'(1);
      ram_rdata_d     = mem[head_q];
    end
    if (issue) begin
      alloc_d[tail_q] = 1'b1;
      tail_d          = tail_q + TAG_BITS'(1);
    end
    if (capture) vld_d[tag_idx] = 1'b1;

    case ({issue, pop})
      2'b10:   outstanding_d = outstanding_q + (TAG_BITS+1)'(1);
      2'b01:   outstanding_d = outstanding_q - (TAG_BITS+1)'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (rd_pend_q) begin
      fifo_d[fifo_wptr_q] = ram_rdata_q;
      fifo_wptr_d         = ~fifo_wptr_q;
    end
    if (deq) fifo_rptr_d = ~fifo_rptr_q;
    fifo_cnt_d = fifo_cnt_q + {1'b0, rd_pend_q} - {1'b0, deq};
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail_q        <= '0;
      head_q        <= '0;
      alloc_q       <= '0;
      vld_q         <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      rd_pend_q     <= 1'b0;
      fifo_q        <= '0;
      fifo_rptr_q   <= 1'b0;
      fifo_wptr_q   <= 1'b0;
      fifo_cnt_q    <= '0;
    end else begin
      tail_q        <= tail_d;
      head_q        <= head_d;
      alloc_q       <= alloc_d;
      vld_q         <= vld_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      rd_pend_q     <= rd_pend_d;
      fifo_q        <= fifo_d;
      fifo_rptr_q   <= fifo_rptr_d;
      fifo_wptr_q   <= fifo_wptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
    end
  end

  // Reorder RAM and its registered read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (capture) mem[tag_idx] <= io_rx_data;
    ram_rdata_q <= ram_rdata_d;
  end

  // Output ports come straight from registers.
  always_comb begin
    usr_rx_valid = (fifo_cnt_q != 2'd0);
    usr_rx_data  = fifo_q[fifo_rptr_q];
    outstanding  = outstanding_q;
    err_stray    = err_q;
  end
endmodule

// File: tb/tb_rd_reorder_requester.sv
// Directed bench for rd_reorder_requester with hand-computed expectations.
module tb_rd_reorder_requester;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         usr_rd_valid, usr_rd_ready;
  logic [31:0]  usr_rd_addr;
  logic         rq_tx_rd_valid, rq_tx_rd_ready;
  logic [44:0]  rq_tx_rd_hdr;
  logic         io_rx_rd_valid;
  logic [12:0]  io_rx_rd_tag;
  logic [511:0] io_rx_data;
  logic         usr_rx_valid, usr_rx_ready;
  logic [511:0] usr_rx_data;
  logic [6:0]   outstanding;
  logic         err_stray;

  int n_tests = 0;
  int n_fail  = 0;

  rd_reorder_requester #(.TAG_BITS(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .usr_rd_valid(usr_rd_valid), .usr_rd_ready(usr_rd_ready), .usr_rd_addr(usr_rd_addr),
    .rq_tx_rd_valid(rq_tx_rd_valid), .rq_tx_rd_ready(rq_tx_rd_ready), .rq_tx_rd_hdr(rq_tx_rd_hdr),
    .io_rx_rd_valid(io_rx_rd_valid), .io_rx_rd_tag(io_rx_rd_tag), .io_rx_data(io_rx_data),
    .usr_rx_valid(usr_rx_valid), .usr_rx_ready(usr_rx_ready), .usr_rx_data(usr_rx_data),
    .outstanding(outstanding), .err_stray(err_stray)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] line(input int i);
    logic [31:0] w;
    w = 32'hA5A5_0000 ^ i;
    return {16{w}};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; #2; rst_n = 1'b1;
  endtask

  task automatic issue(input logic [31:0] a, input int exp_tag);
    int n;
    n = 0;
    usr_rd_valid = 1'b1; usr_rd_addr = a; #1;
    while (!usr_rd_ready && n < 50) begin tick(); n++; end
    chk("issue_ready", usr_rd_ready, 1'b1);
    chk("issue_hdr", rq_tx_rd_hdr, {a, 13'(exp_tag)});
    tick();
    usr_rd_valid = 1'b0;
  endtask

  task automatic respond(input logic [12:0] t, input logic [511:0] d);
    io_rx_rd_valid = 1'b1; io_rx_rd_tag = t; io_rx_data = d;
    tick();
    io_rx_rd_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; usr_rd_valid = 1'b0; usr_rd_addr = '0; rq_tx_rd_ready = 1'b1;
    io_rx_rd_valid = 1'b0; io_rx_rd_tag = '0; io_rx_data = '0; usr_rx_ready = 1'b1;
    #12;
    chk("rst_rx_valid", usr_rx_valid, 1'b0);
    chk("rst_rx_data", usr_rx_data, '0);
    chk("rst_outstanding", outstanding, 7'd0);
    chk("rst_err", err_stray, 1'b0);
    chk("rst_tx_valid", rq_tx_rd_valid, 1'b0);
    chk("rst_rd_ready", usr_rd_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // Single read in order
    issue(32'h0000_1000, 0);
    chk("single_out1", outstanding, 7'd1);
    tick(); tick();
    respond(13'd0, line(100));
    chk("single_e0_valid", usr_rx_valid, 1'b0);
    tick();
    chk("single_e1_valid", usr_rx_valid, 1'b0);
    chk("single_out0", outstanding, 7'd0);
    tick();
    chk("single_e2_valid", usr_rx_valid, 1'b1);
    chk("single_data", usr_rx_data, line(100));
    tick();
    chk("single_drained", usr_rx_valid, 1'b0);

    // Reversed responses
    do_reset(); tick();
    for (int i = 0; i < 4; i++) issue(32'h0000_2000 + 32'(i) * 32'h40, i);
    for (int i = 3; i >= 1; i--) begin
      respond(13'(i), line(200 + i));
      chk("rev_hold", usr_rx_valid, 1'b0);
    end
    tick(); tick();
    chk("rev_hold_idle", usr_rx_valid, 1'b0);
    respond(13'd0, line(200));
    tick();
    chk("rev_e1", usr_rx_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rev_valid", usr_rx_valid, 1'b1);
      chk("rev_data", usr_rx_data, line(200 + i));
    end
    tick();
    chk("rev_done", usr_rx_valid, 1'b0);
    chk("rev_out0", outstanding, 7'd0);

    // Full window and tag wrap
    do_reset(); tick();
    usr_rd_valid = 1'b1; usr_rd_addr = 32'hBEEF_0040;
    for (int i = 0; i < 64; i++) tick();
    chk("full_out", outstanding, 7'd64);
    chk("full_ready", usr_rd_ready, 1'b0);
    chk("full_tx_valid", rq_tx_rd_valid, 1'b0);
    respond(13'd0, line(300));
    chk("full_e0_ready", usr_rd_ready, 1'b0);
    tick();
    chk("wrap_out", outstanding, 7'd63);
    chk("wrap_tx_valid", rq_tx_rd_valid, 1'b1);
    chk("wrap_hdr", rq_tx_rd_hdr, {32'hBEEF_0040, 13'd0});
    tick();
    chk("wrap_refull", outstanding, 7'd64);
    chk("wrap_ready", usr_rd_ready, 1'b0);
    chk("wrap_rx_data", usr_rx_data, line(300));
    usr_rd_valid = 1'b0;

    // Backpressure on the request side
    do_reset(); tick();
    rq_tx_rd_ready = 1'b0; usr_rd_valid = 1'b1; usr_rd_addr = 32'h0000_3000;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_tx_valid", rq_tx_rd_valid, 1'b0);
      tick();
    end
    chk("bp_out", outstanding, 7'd0);
    rq_tx_rd_ready = 1'b1; #1;
    chk("bp_tag_kept", rq_tx_rd_hdr, {32'h0000_3000, 13'd0});
    tick();
    usr_rd_valid = 1'b0;

    // Backpressure on the response side
    do_reset(); tick();
    usr_rx_ready = 1'b0;
    for (int i = 0; i < 8; i++) issue(32'h0000_4000 + 32'(i), i);
    for (int i = 0; i < 8; i++) respond(13'(i), line(400 + i));
    tick(); tick();
    chk("rxbp_two_pops", outstanding, 7'd6);
    for (int i = 0; i < 3; i++) begin
      chk("rxbp_stable", usr_rx_data, line(400));
      tick();
    end
    chk("rxbp_still_6", outstanding, 7'd6);
    usr_rx_ready = 1'b1; #1;
    chk("rxbp_d0", usr_rx_data, line(400));
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("rxbp_valid", usr_rx_valid, 1'b1);
      chk("rxbp_data", usr_rx_data, line(400 + i));
    end
    tick();
    chk("rxbp_empty", usr_rx_valid, 1'b0);

    // Stray and duplicate tags
    do_reset(); tick();
    respond(13'h1000, line(500));
    chk("stray_err", err_stray, 1'b1);
    tick();
    chk("stray_no_out", usr_rx_valid, 1'b0);
    do_reset(); tick();
    usr_rx_ready = 1'b0;
    issue(32'h0000_5000, 0);
    issue(32'h0000_5040, 1);
    respond(13'd1, line(510));
    chk("dup_first_ok", err_stray, 1'b0);
    respond(13'd1, line(511));
    chk("dup_err", err_stray, 1'b1);
    respond(13'd0, line(512));
    tick(); tick(); tick();
    chk("dup_d0", usr_rx_data, line(512));
    usr_rx_ready = 1'b1;
    tick();
    chk("dup_d1_kept", usr_rx_data, line(510));

    // Mid-operation reset
    do_reset(); tick();
    usr_rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) issue(32'h0000_6000 + 32'(i), i);
    respond(13'd0, line(600));
    tick(); tick();
    chk("mid_pre_valid", usr_rx_valid, 1'b1);
    #2 rst_n = 1'b0; #1;
    chk("mid_out0", outstanding, 7'd0);
    chk("mid_valid0", usr_rx_valid, 1'b0);
    chk("mid_data0", usr_rx_data, '0);
    chk("mid_rd_ready", usr_rd_ready, 1'b1);
    #1 rst_n = 1'b1;
    usr_rx_ready = 1'b1;
    tick();
    respond(13'd2, line(602));
    chk("mid_stray", err_stray, 1'b1);
    tick(); tick();
    chk("mid_no_out", usr_rx_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
